// File: rtl/multicycle_control.sv
// Multicycle core controller: IDLE -> FETCH -> EXEC -> (MEM) -> (WB) -> FETCH.
// Datapath controls are Moore-decoded from the state and the opcode latched
// when FETCH accepts an instruction. The only input-dependent output is PC_EN
// on the STORE completion cycle, which follows MEM_ACK.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an undefined
// opcode traps and the core returns to FETCH. Otherwise an undefined opcode halts
// the core.
// Handshake: an opcode transfers on a rising edge where INSTR_READY=1 (FETCH)
// and INSTR_VALID=1. INSTR_VALID is ignored in every other state. MEM_ACK is
// sampled only in MEM. MEM_READ/MEM_WRITE stay high up to and including the
// cycle in which MEM_ACK is seen.
module multicycle_control #(
  parameter int OPW         = 4,
  parameter int HALT_OPCODE = 15,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           START,
  input  logic           INSTR_VALID,
  input  logic [OPW-1:0] OPCODE,
  input  logic           MEM_ACK,
  output logic           INSTR_READY,
  output logic [1:0]     ALU_OP,
  output logic [1:0]     ALU_SRC_B,
  output logic           REG_WRITE,
  output logic           BRANCH,
  output logic           MEM_WRITE,
  output logic           MEM_READ,
  output logic           REG_DST,
  output logic           MEM_TO_REG,
  output logic           PC_EN,
  output logic           HALT,
  output logic           MEM_ERR,
  output logic           TRAP,
  output logic [2:0]     DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [1:0] kADD = 2'd0;
  localparam logic [1:0] kSUB = 2'd1;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_STORE = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQZ  = OPW'(3);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(HALT_OPCODE);

  // The last MEM cycle (counted from 0) in which an acknowledge is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [7:0]     wait_q, wait_d;
  logic           mem_err_q, mem_err_d;

  logic is_load, is_addi, is_store, is_beqz, is_halt, is_illegal;

  assign is_load    = (opcode_q == OP_LOAD);
  assign is_addi    = (opcode_q == OP_ADDI);
  assign is_store   = (opcode_q == OP_STORE);
  assign is_beqz    = (opcode_q == OP_BEQZ);
  assign is_halt    = (opcode_q == OP_HALT);
  assign is_illegal = !(is_load || is_addi || is_store || is_beqz || is_halt);

  assign MEM_ERR   = mem_err_q;
  assign DBG_STATE = state_q;

  // State, latched opcode, MEM wait counter and sticky error flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic, opcode capture and MEM timeout tracking.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_FETCH;
      S_FETCH: begin
        if (INSTR_VALID) begin
          opcode_d = OPCODE;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (is_load || is_store) state_d = S_MEM;
        else if (is_addi)        state_d = S_WB;
        else if (is_beqz)        state_d = S_FETCH;
        else if (is_halt)        state_d = S_HALTED;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_FETCH;
`else
          state_d = S_HALTED;
`endif
        end
      end
      S_MEM: begin
        // An acknowledge in the last allowed cycle takes priority over the timeout.
        if (MEM_ACK) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = S_HALTED;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control outputs, decoded from the state and the latched opcode.
  always_comb begin
    INSTR_READY = 1'b0;
    ALU_OP      = kADD;
    ALU_SRC_B   = 2'd0;
    REG_WRITE   = 1'b0;
    BRANCH      = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_READ    = 1'b0;
    REG_DST     = 1'b0;
    MEM_TO_REG  = 1'b0;
    PC_EN       = 1'b0;
    HALT        = 1'b0;
    TRAP        = 1'b0;
    // Datapath selects stay steady from EXEC through the write-back of the instruction.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      ALU_OP     = is_beqz ? kSUB : kADD;
      ALU_SRC_B  = is_addi ? 2'd1 : 2'd2;
      REG_DST    = !is_addi;
      MEM_TO_REG = !is_load;
    end
    case (state_q)
      S_FETCH: INSTR_READY = 1'b1;
      S_EXEC: begin
        BRANCH = is_beqz;
        PC_EN  = is_beqz;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (is_illegal) begin
          TRAP  = 1'b1;
          PC_EN = 1'b1;
        end
`endif
      end
      S_MEM: begin
        MEM_READ  = is_load;
        MEM_WRITE = is_store;
        PC_EN     = is_store && MEM_ACK;
      end
      S_WB: begin
        REG_WRITE = 1'b1;
        PC_EN     = 1'b1;
      end
      S_HALTED: HALT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (default parameters).
// Build with +define+CTRL_ILLEGAL_TRAP_EN to check the trap variant.
module tb_multicycle_control;

  localparam int TO = 15;

  // Expected-output vector bit positions (see out_vec packing below).
  localparam logic [15:0] E_IR  = 16'h8000;
  localparam logic [15:0] E_SUB = 16'h2000;
  localparam logic [15:0] E_SB1 = 16'h0800;
  localparam logic [15:0] E_SB2 = 16'h1000;
  localparam logic [15:0] E_RW  = 16'h0400;
  localparam logic [15:0] E_BR  = 16'h0200;
  localparam logic [15:0] E_MW  = 16'h0100;
  localparam logic [15:0] E_MR  = 16'h0080;
  localparam logic [15:0] E_RD  = 16'h0040;
  localparam logic [15:0] E_M2R = 16'h0020;
  localparam logic [15:0] E_PC  = 16'h0010;
  localparam logic [15:0] E_HLT = 16'h0008;
  localparam logic [15:0] E_ERR = 16'h0004;
  localparam logic [15:0] E_TRP = 16'h0002;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       INSTR_VALID = 1'b0;
  logic [3:0] OPCODE = 4'd0;
  logic       MEM_ACK = 1'b0;
  logic       INSTR_READY, REG_WRITE, BRANCH, MEM_WRITE, MEM_READ, REG_DST;
  logic       MEM_TO_REG, PC_EN, HALT, MEM_ERR, TRAP;
  logic [1:0] ALU_OP, ALU_SRC_B;
  logic [2:0] DBG_STATE;
  logic [15:0] out_vec;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.OPW(4), .HALT_OPCODE(15), .MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .INSTR_VALID(INSTR_VALID),
    .OPCODE(OPCODE), .MEM_ACK(MEM_ACK), .INSTR_READY(INSTR_READY),
    .ALU_OP(ALU_OP), .ALU_SRC_B(ALU_SRC_B), .REG_WRITE(REG_WRITE),
    .BRANCH(BRANCH), .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
    .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG), .PC_EN(PC_EN), .HALT(HALT),
    .MEM_ERR(MEM_ERR), .TRAP(TRAP), .DBG_STATE(DBG_STATE)
  );

  assign out_vec = {INSTR_READY, ALU_OP, ALU_SRC_B, REG_WRITE, BRANCH, MEM_WRITE,
                    MEM_READ, REG_DST, MEM_TO_REG, PC_EN, HALT, MEM_ERR, TRAP, 1'b0};

  // Clock.
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic score(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {16'd0, out_vec}, {16'd0, e});
    end
  endtask

  // Drive one cycle of inputs just after the edge, and score at the falling edge.
  task automatic cyc(input logic st, input logic iv, input logic [3:0] op,
                     input logic ack, input logic [15:0] exp, input string tag);
    @(posedge CLK);
    #1;
    START = st; INSTR_VALID = iv; OPCODE = op; MEM_ACK = ack;
    exp_q.push_back(exp);
    @(negedge CLK);
    score(tag);
  endtask

  task automatic do_reset();
    START = 0; INSTR_VALID = 0; MEM_ACK = 0; OPCODE = 0;
    RESET = 1'b1;
    #1;
    exp_q.push_back(16'd0);
    score("reset_outputs");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Datapath selects expected for an opcode in EXEC/MEM/WB.
  function automatic logic [15:0] dp_of(input int op);
    case (op)
      0:       return E_SB2 | E_RD;
      1:       return E_SB1 | E_M2R;
      3:       return E_SUB | E_SB2 | E_RD | E_M2R;
      default: return E_SB2 | E_RD | E_M2R;
    endcase
  endfunction

  // One instruction from FETCH back to FETCH. d = MEM cycles until the acknowledge.
  // Non-FETCH cycles drive INSTR_VALID with opcode 15 and stray acknowledges,
  // which the controller must ignore.
  task automatic run_instr(input int op, input int d);
    logic [15:0] dp;
    dp = dp_of(op);
    cyc(0, 1, 4'(op), 0, E_IR, $sformatf("fetch_op%0d", op));
    case (op)
      1: begin
        cyc(0, 1, 4'd15, 1, dp, "exec_addi");
        cyc(0, 1, 4'd15, 1, dp | E_RW | E_PC, "wb_addi");
      end
      3: cyc(0, 1, 4'd15, 1, dp | E_BR | E_PC, "exec_beqz");
      default: begin
        cyc(0, 1, 4'd15, 1, dp, $sformatf("exec_op%0d", op));
        for (int k = 0; k < d; k++) begin
          if (op == 0)
            cyc(0, 1, 4'd15, (k == d - 1), dp | E_MR, $sformatf("mem_load_k%0d", k));
          else
            cyc(0, 1, 4'd15, (k == d - 1), dp | E_MW | ((k == d - 1) ? E_PC : 16'd0),
                $sformatf("mem_store_k%0d", k));
        end
        if (op == 0) cyc(0, 1, 4'd15, 1, dp | E_RW | E_PC, "wb_load");
      end
    endcase
  endtask

  initial begin
    #2;
    do_reset();
    check_eq("idle_dbg_state", {29'd0, DBG_STATE}, 32'd0);
    cyc(0, 1, 4'd1, 1, 16'd0, "idle_no_start");
    cyc(1, 0, 4'd0, 0, 16'd0, "idle_start_cycle");

    // Directed instructions.
    run_instr(1, 0);
    cyc(0, 0, 4'd0, 1, E_IR, "fetch_wait_ack_ignored");
    run_instr(0, 3);
    run_instr(2, 2);
    run_instr(3, 0);
    run_instr(0, 1);
    run_instr(2, TO);   // acknowledge in the final allowed cycle

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      run_instr($urandom_range(0, 3), $urandom_range(1, TO));
    end

    // STORE never acknowledged: timeout, sticky error, halt.
    cyc(0, 1, 4'd2, 0, E_IR, "fetch_store_to");
    cyc(0, 0, 4'd0, 0, dp_of(2), "exec_store_to");
    for (int k = 0; k < TO; k++)
      cyc(0, 0, 4'd0, 0, dp_of(2) | E_MW, $sformatf("mem_to_k%0d", k));
    cyc(0, 0, 4'd0, 0, E_HLT | E_ERR, "halted_after_timeout");
    cyc(1, 1, 4'd1, 1, E_HLT | E_ERR, "halted_ignores_start");
    cyc(1, 0, 4'd0, 0, E_HLT | E_ERR, "halted_sticky");

    // Reset in the middle of a LOAD.
    do_reset();
    cyc(1, 0, 4'd0, 0, 16'd0, "idle_start2");
    cyc(0, 1, 4'd0, 0, E_IR, "fetch_load_rst");
    cyc(0, 0, 4'd0, 0, dp_of(0), "exec_load_rst");
    cyc(0, 0, 4'd0, 0, dp_of(0) | E_MR, "mem_load_rst");
    RESET = 1'b1;
    #1;
    exp_q.push_back(16'd0);
    score("reset_mid_mem");
    @(negedge CLK);
    RESET = 1'b0;
    cyc(0, 0, 4'd0, 1, 16'd0, "idle_after_rst");
    cyc(0, 1, 4'd0, 0, 16'd0, "idle_after_rst2");
    check_eq("dbg_idle_after_rst", {29'd0, DBG_STATE}, 32'd0);

    // HALT opcode.
    cyc(1, 0, 4'd0, 0, 16'd0, "idle_start3");
    cyc(0, 1, 4'd15, 0, E_IR, "fetch_halt");
    cyc(0, 0, 4'd0, 0, dp_of(15), "exec_halt");
    cyc(1, 1, 4'd1, 0, E_HLT, "halted_op15");

    // Undefined opcode 7.
    do_reset();
    cyc(1, 0, 4'd0, 0, 16'd0, "idle_start4");
    cyc(0, 1, 4'd7, 0, E_IR, "fetch_illegal");
`ifdef CTRL_ILLEGAL_TRAP_EN
    cyc(0, 0, 4'd0, 0, dp_of(7) | E_TRP | E_PC, "exec_illegal_trap");
    cyc(0, 0, 4'd0, 0, E_IR, "fetch_after_trap");
    run_instr(1, 0);
`else
    cyc(0, 0, 4'd0, 0, dp_of(7), "exec_illegal");
    cyc(0, 0, 4'd0, 0, E_HLT, "halted_illegal");
`endif

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
